// File: rtl/seq_div_8by4.sv
// seq_div_8by4: sequential restoring divider, one quotient bit per clock, start/busy/done handshake
module seq_div_8by4 #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_zero
);
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        state_q, state_d;
    logic [VW:0]   pr_q, pr_d, pr_sh;
    logic [DW-1:0] qsh_q, qsh_d, quo_q, quo_d;
    logic [VW-1:0] dvs_q, dvs_d, rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dz_q, dz_d, ge;
    always_comb begin
        pr_sh   = {pr_q[VW-1:0], qsh_q[DW-1]};
        ge      = pr_sh >= {1'b0, dvs_q};
        state_d = state_q;
        pr_d    = pr_q;
        qsh_d   = qsh_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                pr_d    = '0;
                qsh_d   = dividend;
                dvs_d   = divisor;
                cnt_d   = CW'(DW - 1);
            end
            RUN: begin
                pr_d  = ge ? pr_sh - {1'b0, dvs_q} : pr_sh;
                qsh_d = {qsh_q[DW-2:0], ge};
                cnt_d = cnt_q - CW'(1);
                // results are registered on the final iteration so they are valid throughout DONE
                if (cnt_q == '0) begin
                    state_d = DONE;
                    dz_d    = dvs_q == '0;
                    quo_d   = dz_d ? '1 : qsh_d;
                    rem_d   = dz_d ? '0 : pr_d[VW-1:0];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pr_q    <= '0;
            qsh_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pr_q    <= pr_d;
            qsh_q   <= qsh_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;
endmodule
